// File: rtl/trace_pattern_matcher.sv
// Trace pattern matcher: deserialises TPIU lanes, aligns on the sync
// word and compares each byte-aligned history buffer to masked rules.
module trace_pattern_matcher #(
  parameter int pBUFFER_SIZE = 64,
  parameter int pMATCH_RULES = 8
) (
  input  logic                                 trace_clk,
  input  logic                                 reset_n,
  input  logic [3:0]                           I_trace_data,
  input  logic [2:0]                           I_trace_width,
  input  logic                                 I_trace_reset_sync,
  input  logic [pMATCH_RULES-1:0]              I_pattern_enable,
  input  logic [pMATCH_RULES-1:0]              I_pattern_trig_enable,
  input  logic [pMATCH_RULES*pBUFFER_SIZE-1:0] I_trace_patterns,
  input  logic [pMATCH_RULES*pBUFFER_SIZE-1:0] I_trace_masks,
  output logic                                 O_synchronized,
  output logic                                 O_match_valid,
  output logic [pMATCH_RULES-1:0]              O_matching_pattern,
  output logic                                 O_trigger,
  output logic [8*pMATCH_RULES-1:0]            O_trace_counts,
  output logic [pBUFFER_SIZE-1:0]              O_matched_data
);

  localparam int N = pBUFFER_SIZE;
  localparam int R = pMATCH_RULES;

  logic [N-1:0] hist;
  logic [N-1:0] hist_nx;
  logic [2:0]   lanes;
  logic [2:0]   prev_width;
  logic [3:0]   bitcnt;
  logic [3:0]   bit_sum;
  logic         byte_rdy;
  logic         sync_hit;
  logic         width_chg;
  logic         compare;
  logic [R-1:0] hit;

  // Newest sample enters at the top; lane 0 is the oldest bit of it.
  always_comb begin
    lanes   = 3'd4;
    hist_nx = {I_trace_data, hist[N-1:4]};
    unique case (1'b1)
      (I_trace_width == 3'd1): begin
        lanes   = 3'd1;
        hist_nx = {I_trace_data[0], hist[N-1:1]};
      end
      (I_trace_width == 3'd2): begin
        lanes   = 3'd2;
        hist_nx = {I_trace_data[1:0], hist[N-1:2]};
      end
      default: ;
    endcase
  end

  assign bit_sum   = bitcnt + {1'b0, lanes};
  assign sync_hit  = (hist[N-1 -: 32] == 32'h7FFF_FFFF);
  assign width_chg = (I_trace_width != prev_width);
  assign compare   = byte_rdy & O_synchronized
                   & ~I_trace_reset_sync;

  always_comb begin
    hit = '0;
    for (int i = 0; i < R; i++) begin
      hit[i] = I_pattern_enable[i]
             & ~|((hist ^ I_trace_patterns[i*N +: N])
                  & I_trace_masks[i*N +: N]);
    end
  end

  always_ff @(posedge trace_clk or negedge reset_n) begin
    if (!reset_n) begin
      hist               <= '0;
      prev_width         <= 3'd4;
      bitcnt             <= '0;
      byte_rdy           <= 1'b0;
      O_synchronized     <= 1'b0;
      O_match_valid      <= 1'b0;
      O_matching_pattern <= '0;
      O_trigger          <= 1'b0;
      O_trace_counts     <= '0;
      O_matched_data     <= '0;
    end else begin
      hist          <= hist_nx;
      prev_width    <= I_trace_width;
      O_match_valid <= 1'b0;
      O_trigger     <= 1'b0;

      if (I_trace_reset_sync || width_chg) begin
        O_synchronized <= 1'b0;
        bitcnt         <= '0;
        byte_rdy       <= 1'b0;
      end else if (sync_hit) begin
        // The sample landing now is the first of the next byte.
        O_synchronized <= 1'b1;
        bitcnt         <= {1'b0, lanes};
        byte_rdy       <= 1'b0;
      end else if (O_synchronized) begin
        if (bit_sum >= 4'd8) begin
          bitcnt   <= '0;
          byte_rdy <= 1'b1;
        end else begin
          bitcnt   <= bit_sum;
          byte_rdy <= 1'b0;
        end
      end else begin
        bitcnt   <= '0;
        byte_rdy <= 1'b0;
      end

      if (I_trace_reset_sync) begin
        O_trace_counts <= '0;
      end else if (compare && |hit) begin
        O_match_valid      <= 1'b1;
        O_trigger          <= |(hit & I_pattern_trig_enable);
        O_matching_pattern <= hit;
        O_matched_data     <= hist;
        for (int i = 0; i < R; i++) begin
          if (hit[i] && O_trace_counts[i*8 +: 8] != 8'hFF)
            O_trace_counts[i*8 +: 8] <=
              O_trace_counts[i*8 +: 8] + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_trace_pattern_matcher.sv
// Directed bench for trace_pattern_matcher: sync, match, saturation,
// clear, width change, 1-lane operation and asynchronous reset.
module tb_trace_pattern_matcher;

  logic         trace_clk = 1'b0;
  logic         reset_n;
  logic [3:0]   I_trace_data;
  logic [2:0]   I_trace_width;
  logic         I_trace_reset_sync;
  logic [7:0]   I_pattern_enable;
  logic [7:0]   I_pattern_trig_enable;
  logic [511:0] I_trace_patterns;
  logic [511:0] I_trace_masks;
  logic         O_synchronized;
  logic         O_match_valid;
  logic [7:0]   O_matching_pattern;
  logic         O_trigger;
  logic [63:0]  O_trace_counts;
  logic [63:0]  O_matched_data;

  int tests = 0;
  int fails = 0;
  int mv_cnt = 0;
  int tr_cnt = 0;
  int mv_base;
  int tr_base;

  logic [7:0] a5_lsb;

  trace_pattern_matcher dut (
    .trace_clk             (trace_clk),
    .reset_n               (reset_n),
    .I_trace_data          (I_trace_data),
    .I_trace_width         (I_trace_width),
    .I_trace_reset_sync    (I_trace_reset_sync),
    .I_pattern_enable      (I_pattern_enable),
    .I_pattern_trig_enable (I_pattern_trig_enable),
    .I_trace_patterns      (I_trace_patterns),
    .I_trace_masks         (I_trace_masks),
    .O_synchronized        (O_synchronized),
    .O_match_valid         (O_match_valid),
    .O_matching_pattern    (O_matching_pattern),
    .O_trigger             (O_trigger),
    .O_trace_counts        (O_trace_counts),
    .O_matched_data        (O_matched_data)
  );

  always #5 trace_clk = ~trace_clk;

  always @(negedge trace_clk) begin
    if (O_match_valid === 1'b1) mv_cnt++;
    if (O_trigger === 1'b1)     tr_cnt++;
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] d);
    I_trace_data = d;
    @(posedge trace_clk);
    #1;
  endtask

  task automatic sync4();
    for (int i = 0; i < 7; i++) step(4'hF);
    step(4'h7);
  endtask

  initial begin
    reset_n               = 1'b0;
    I_trace_data          = 4'h0;
    I_trace_width         = 3'd4;
    I_trace_reset_sync    = 1'b0;
    I_pattern_enable      = 8'h00;
    I_pattern_trig_enable = 8'h00;
    I_trace_patterns      = '0;
    I_trace_masks         = '0;
    I_trace_patterns[63:0]    = 64'hA500_0000_0000_0000;
    I_trace_masks[63:0]       = 64'hFF00_0000_0000_0000;
    I_trace_patterns[191:128] = 64'h5A00_0000_0000_0000;
    I_trace_masks[191:128]    = 64'hFF00_0000_0000_0000;
    a5_lsb = 8'hA5;

    repeat (2) @(posedge trace_clk);
    #1;
    check("rst_sync", {63'd0, O_synchronized}, 64'd0);
    check("rst_mv", {63'd0, O_match_valid}, 64'd0);
    check("rst_counts", O_trace_counts, 64'd0);
    check("rst_data", O_matched_data, 64'd0);
    reset_n = 1'b1;
    step(4'h0);

    // 4-lane sync with no rules enabled
    mv_base = mv_cnt;
    sync4();
    check("sync_lat_pre", {63'd0, O_synchronized}, 64'd0);
    step(4'h0);
    check("sync_4lane", {63'd0, O_synchronized}, 64'd1);
    step(4'h5);
    step(4'hA);
    step(4'h0);
    step(4'h0);
    check("no_rule_mv", 64'(mv_cnt - mv_base), 64'd0);

    // single match with trigger
    I_pattern_enable      = 8'h05;
    I_pattern_trig_enable = 8'h01;
    I_trace_reset_sync = 1'b1;
    step(4'h0);
    I_trace_reset_sync = 1'b0;
    mv_base = mv_cnt;
    tr_base = tr_cnt;
    sync4();
    step(4'h5);
    check("m_sync", {63'd0, O_synchronized}, 64'd1);
    step(4'hA);
    check("m_mv_early", {63'd0, O_match_valid}, 64'd0);
    step(4'h0);
    check("m_mv", {63'd0, O_match_valid}, 64'd1);
    check("m_trig", {63'd0, O_trigger}, 64'd1);
    check("m_pat", {56'd0, O_matching_pattern}, 64'h01);
    check("m_cnt0", {56'd0, O_trace_counts[7:0]}, 64'd1);
    check("m_data", {56'd0, O_matched_data[63:56]}, 64'hA5);
    step(4'h0);
    check("m_mv_pulse", {63'd0, O_match_valid}, 64'd0);
    check("m_trig_pulse", {63'd0, O_trigger}, 64'd0);
    check("m_mv_cnt", 64'(mv_cnt - mv_base), 64'd1);
    check("m_tr_cnt", 64'(tr_cnt - tr_base), 64'd1);

    // saturation, trigger disabled
    I_pattern_trig_enable = 8'h00;
    mv_base = mv_cnt;
    tr_base = tr_cnt;
    for (int i = 0; i < 300; i++) begin
      step(4'h5);
      step(4'hA);
    end
    step(4'h0);
    step(4'h0);
    check("sat_cnt0", {56'd0, O_trace_counts[7:0]}, 64'd255);
    check("sat_cnt2", {56'd0, O_trace_counts[23:16]}, 64'd0);
    check("sat_mv_cnt", 64'(mv_cnt - mv_base), 64'd300);
    check("sat_tr_cnt", 64'(tr_cnt - tr_base), 64'd0);
    check("sat_pat", {56'd0, O_matching_pattern}, 64'h01);

    // clear, then no matches without a new sync word
    I_trace_reset_sync = 1'b1;
    step(4'h5);
    check("clr_sync", {63'd0, O_synchronized}, 64'd0);
    check("clr_counts", O_trace_counts, 64'd0);
    I_trace_reset_sync = 1'b0;
    mv_base = mv_cnt;
    for (int i = 0; i < 20; i++) begin
      step(4'h5);
      step(4'hA);
    end
    step(4'h0);
    check("nosync_mv", 64'(mv_cnt - mv_base), 64'd0);

    // width change clears sync
    sync4();
    step(4'h0);
    check("wc_sync_pre", {63'd0, O_synchronized}, 64'd1);
    I_trace_width = 3'd2;
    step(4'h0);
    check("wc_sync", {63'd0, O_synchronized}, 64'd0);
    step(4'h0);

    // 1-lane: sync word LSB-first then byte A5
    I_trace_width = 3'd1;
    for (int i = 0; i < 31; i++) step(4'h1);
    step(4'h0);
    check("l1_sync_pre", {63'd0, O_synchronized}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      step({3'b000, a5_lsb[i]});
      if (i == 0)
        check("l1_sync", {63'd0, O_synchronized}, 64'd1);
    end
    check("l1_mv_early", {63'd0, O_match_valid}, 64'd0);
    step(4'h0);
    check("l1_mv", {63'd0, O_match_valid}, 64'd1);
    check("l1_trig", {63'd0, O_trigger}, 64'd0);
    check("l1_cnt0", {56'd0, O_trace_counts[7:0]}, 64'd1);
    check("l1_data", {56'd0, O_matched_data[63:56]}, 64'hA5);

    // asynchronous reset without a clock edge
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_sync", {63'd0, O_synchronized}, 64'd0);
    check("ar_mv", {63'd0, O_match_valid}, 64'd0);
    check("ar_pat", {56'd0, O_matching_pattern}, 64'd0);
    check("ar_counts", O_trace_counts, 64'd0);
    check("ar_data", O_matched_data, 64'd0);
    @(posedge trace_clk);
    #1;
    reset_n = 1'b1;
    step(4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trace_pattern_matcher.md
# trace_pattern_matcher

Matches the captured TPIU trace stream against the eight pattern/mask rules programmed through the trace register block. It sits between the trace capture front-end and the register block. It deserialises 1/2/4-lane trace data into a 64-bit history buffer and detects the TPIU sync word to establish byte alignment. On every byte boundary it compares the buffer against each enabled rule, then reports per-rule hit counts, the matched buffer contents and a trigger pulse back to the register block and the capture logic.

## Interface
- pBUFFER_SIZE, 64, history buffer and pattern/mask width in bits; multiple of 8, ≥32.
- pMATCH_RULES, 8, number of pattern/mask rules.
- trace_clk  in  1  trace-domain clock. One clock; reset is asynchronous and active-low.
- reset_n  in  1  asynchronous active-low reset.
- I_trace_data  in  4  lane data sampled each trace_clk; lane 0 is the earliest bit.
- I_trace_width  in  3  active lanes. 1 → lane 0; 2 → lanes 1:0; any other value → 4 lanes.
- I_trace_reset_sync  in  1  level; while high, clears sync and counters.
- I_pattern_enable  in  pMATCH_RULES  per-rule match enable.
- I_pattern_trig_enable  in  pMATCH_RULES  per-rule trigger enable.
- I_trace_patterns  in  pMATCH_RULES*pBUFFER_SIZE  rule i at [i*pBUFFER_SIZE +: pBUFFER_SIZE].
- I_trace_masks  in  pMATCH_RULES*pBUFFER_SIZE  same slicing; 1 = bit compared.
- O_synchronized  out  1  sync word seen since last clear.
- O_match_valid  out  1  one-cycle pulse: at least one rule matched.
- O_matching_pattern  out  pMATCH_RULES  hit vector of the last match event.
- O_trigger  out  1  one-cycle pulse: a hit on a trigger-enabled rule.
- O_trace_counts  out  8*pMATCH_RULES  rule i count at [i*8 +: 8], saturating.
- O_matched_data  out  pBUFFER_SIZE  buffer snapshot at the last match event.

## Operation
- Shift in: each edge, with w = active lanes: buf <= {I_trace_data[w-1:0], buf[pBUFFER_SIZE-1:w]}. Buffer shifts regardless of sync state.
- Sync detection: sync_hit = (buf[pBUFFER_SIZE-1 -: 32] == 32'h7FFF_FFFF).
  - On the next edge: O_synchronized <= 1 and bitcnt restarts at w.
  - Sync detection is active while synchronized and re-aligns the bit count.
- Byte tracking: when synchronized, bitcnt += w each edge.
  - When the sum reaches 8: byte_rdy <= 1 for one cycle and bitcnt <= 0.
  - A sync_hit edge never produces byte_rdy.
- Compare: when byte_rdy and synchronized, hit[i] = I_pattern_enable[i] & (((buf ^ pattern_i) & mask_i) == 0).
  - If any hit[i] is set: O_match_valid pulses, O_matching_pattern <= hit, and O_matched_data <= buf.
  - Each hit counter increments and saturates at 255.
  - O_trigger pulses if (hit & I_pattern_trig_enable) != 0.
- Width change: if I_trace_width differs from its registered previous value, synchronized, bitcnt and byte_rdy clear on the next edge.
- I_trace_reset_sync high: synchronized, bitcnt, byte_rdy and all counters clear. The buffer keeps shifting. Sync can be reacquired only after the input drops.
- Quasi-static inputs: patterns, masks and enables come from the USB clock domain and are written only while matching is disabled. This block contains no CDC for them.

## Timing
- Reset values: buf = 0, bitcnt = 0, byte_rdy = 0, previous width = 4, O_synchronized = 0, O_match_valid = 0, O_matching_pattern = 0, O_trigger = 0, O_trace_counts = 0, O_matched_data = 0.
- Reset is asynchronous; all state clears without a clock edge.
- Sync latency: the sample completing the sync word lands at edge k; O_synchronized is high after edge k+1.
- Match latency: the sample completing a byte lands at edge m; byte_rdy is high after m; O_match_valid, O_trigger, counts and O_matched_data update at edge m+1.
- Pulse width: O_match_valid and O_trigger are single-cycle. Back-to-back bytes (4 lanes → every 2 cycles) give separate pulses.
- Simultaneous events:
  - sync_hit and byte_rdy in the same cycle: compare happens, bitcnt restarts.
  - I_trace_reset_sync and byte_rdy in the same cycle: reset wins, no count increment.
- Wrap-around: counters hold at 255 and never wrap.

## Test plan
- Reset: assert reset_n low mid-stream with no clock → all outputs 0 immediately; counts 0; O_synchronized 0.
- 4-lane sync: feed nibbles F,F,F,F,F,F,F,7 → O_synchronized high on the edge after nibble 7; with no enabled rules, O_match_valid stays 0.
- Single match: set mask0 = 64'hFF00_0000_0000_0000, pattern0 = 64'hA500_0000_0000_0000, enable = 8'h01, trig_enable = 8'h01. After sync, feed nibbles 5 then A → one O_match_valid pulse and one O_trigger pulse; O_matching_pattern = 8'h01; count0 = 1; O_matched_data[63:56] = 8'hA5.
- Saturation and no-trigger: same rule with trig_enable = 0; feed 300 bytes of A5 → count0 = 255, O_trigger never asserts, 300 O_match_valid pulses.
- 1-lane width: width = 1; send the 32 sync bits serially, then byte A5 LSB-first → O_match_valid exactly 8 cycles after sync alignment. Without the sync word, no matches occur.
- Clear: pulse I_trace_reset_sync during the stream → O_synchronized = 0, counts = 0. Changing width from 4 to 2 also clears O_synchronized. Matching resumes only after a new sync word.
